alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 38 +++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// result flag layout and ALU opcode values.
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ALUC_W = 4;
    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVF   = 0;

    localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic zero, input logic carry,
                                                      input logic negative, input logic overflow);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_NEG]   = negative;
        f[FLAG_OVF]   = overflow;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: round-robin on a last-granted pointer, or fixed
// priority to requester 0 when PRIO_FIXED is nonzero.
module rr_arbiter2 #(
    parameter int PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // Holds the id of the most recently accepted requester; reset value 1
    // makes requester 0 the favoured one after reset.
    logic last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (PRIO_FIXED != 0) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one
// operation in flight at a time: IDLE (accept) -> EXEC (capture) -> RESP.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [ALUC_W-1:0] req0_aluc,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_r,
    output logic [FLAG_W-1:0] rsp0_flags,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [ALUC_W-1:0] req1_aluc,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_r,
    output logic [FLAG_W-1:0] rsp1_flags,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [ALUC_W-1:0] alu_aluc,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    input  logic              alu_overflow,

    output logic              busy
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] op_a_p0, op_b_p0;
    logic [ALUC_W-1:0] op_aluc_p0;
    logic              owner_p0;
    logic [DATA_W-1:0] res_r_p1;
    logic [FLAG_W-1:0] res_flags_p1;

    logic [1:0] req_vld;
    logic [1:0] gnt;
    logic       accept;
    logic       rsp_fire;

    assign req_vld = {req1_valid, req0_valid};

    rr_arbiter2 #(
        .PRIO_FIXED(PRIO_FIXED)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_vld),
        .accept(accept),
        .gnt   (gnt)
    );

    assign accept     = (state == ST_IDLE) && !rst && (gnt != 2'b00);
    assign req0_ready = accept && gnt[0];
    assign req1_ready = accept && gnt[1];
    assign rsp_fire   = (state == ST_RESP) && (owner_p0 ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = ST_EXEC;
            ST_EXEC:               state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: operation latched from the granted requester on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_p0    <= '0;
            op_b_p0    <= '0;
            op_aluc_p0 <= '0;
            owner_p0   <= 1'b0;
        end else if (accept) begin
            owner_p0   <= gnt[1];
            op_a_p0    <= gnt[1] ? req1_a    : req0_a;
            op_b_p0    <= gnt[1] ? req1_b    : req0_b;
            op_aluc_p0 <= gnt[1] ? req1_aluc : req0_aluc;
        end
    end

    // Stage p1: ALU result captured in EXEC, held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r_p1     <= '0;
            res_flags_p1 <= '0;
        end else if (state == ST_EXEC) begin
            res_r_p1     <= alu_r;
            res_flags_p1 <= pack_flags(alu_zero, alu_carry, alu_negative, alu_overflow);
        end
    end

    // Outputs are forced quiet while reset is applied, since reset only takes
    // effect on the next edge.
    assign alu_a    = rst ? '0 : op_a_p0;
    assign alu_b    = rst ? '0 : op_b_p0;
    assign alu_aluc = rst ? '0 : op_aluc_p0;

    assign rsp0_valid = !rst && (state == ST_RESP) && !owner_p0;
    assign rsp1_valid = !rst && (state == ST_RESP) &&  owner_p0;
    assign rsp0_r     = res_r_p1;
    assign rsp1_r     = res_r_p1;
    assign rsp0_flags = res_flags_p1;
    assign rsp1_flags = res_flags_p1;

    assign busy = !rst && (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response
// scoreboard; a second instance checks fixed-priority granting.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // round-robin instance
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_a, req0_b, rsp0_r;
    logic [3:0]  req0_aluc, rsp0_flags;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_a, req1_b, rsp1_r;
    logic [3:0]  req1_aluc, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow, busy;
    logic [35:0] alu_out;

    // fixed-priority instance
    logic        f_req0_valid, f_req0_ready, f_rsp0_valid;
    logic        f_req1_valid, f_req1_ready, f_rsp1_valid;
    logic [31:0] f_rsp0_r, f_rsp1_r, f_alu_a, f_alu_b, f_alu_r;
    logic [3:0]  f_rsp0_flags, f_rsp1_flags, f_alu_aluc;
    logic        f_alu_zero, f_alu_carry, f_alu_negative, f_alu_overflow, f_busy;
    logic [35:0] f_alu_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        own;
        logic [3:0]  f;
        logic [31:0] r;
    } exp_t;
    exp_t sb[$];

    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALUC_ADDU, ALUC_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                if (op == ALUC_ADD) v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALUC_SUBU, ALUC_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = w[32];
                if (op == ALUC_SUB) v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALUC_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUC_SLL: r = b << a[4:0];
            default:  r = a & b;
        endcase
        return {(r == 32'd0), c, r[31], v, r};
    endfunction

    assign alu_out      = alu_model(alu_a, alu_b, alu_aluc);
    assign alu_r        = alu_out[31:0];
    assign alu_zero     = alu_out[35];
    assign alu_carry    = alu_out[34];
    assign alu_negative = alu_out[33];
    assign alu_overflow = alu_out[32];

    assign f_alu_out      = alu_model(f_alu_a, f_alu_b, f_alu_aluc);
    assign f_alu_r        = f_alu_out[31:0];
    assign f_alu_zero     = f_alu_out[35];
    assign f_alu_carry    = f_alu_out[34];
    assign f_alu_negative = f_alu_out[33];
    assign f_alu_overflow = f_alu_out[32];

    alu_arbiter #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_aluc(req0_aluc), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_r(rsp0_r), .rsp0_flags(rsp0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_aluc(req1_aluc), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_r(rsp1_r), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .busy(busy)
    );

    alu_arbiter #(.PRIO_FIXED(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(32'd3), .req0_b(32'd4),
        .req0_aluc(ALUC_ADDU), .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1),
        .rsp0_r(f_rsp0_r), .rsp0_flags(f_rsp0_flags),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(32'd9), .req1_b(32'd2),
        .req1_aluc(ALUC_SUBU), .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1),
        .rsp1_r(f_rsp1_r), .rsp1_flags(f_rsp1_flags),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_aluc(f_alu_aluc), .alu_r(f_alu_r),
        .alu_zero(f_alu_zero), .alu_carry(f_alu_carry), .alu_negative(f_alu_negative),
        .alu_overflow(f_alu_overflow), .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic own, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
        logic [35:0] m;
        exp_t e;
        m     = alu_model(a, b, op);
        e.own = own;
        e.f   = m[35:32];
        e.r   = m[31:0];
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_pending"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.own) begin
            chk({tag, "_rsp1_valid"}, rsp1_valid, 1'b1);
            chk({tag, "_rsp0_quiet"}, rsp0_valid, 1'b0);
            chk({tag, "_r"}, rsp1_r, e.r);
            chk({tag, "_flags"}, rsp1_flags, e.f);
        end else begin
            chk({tag, "_rsp0_valid"}, rsp0_valid, 1'b1);
            chk({tag, "_rsp1_quiet"}, rsp1_valid, 1'b0);
            chk({tag, "_r"}, rsp0_r, e.r);
            chk({tag, "_flags"}, rsp0_flags, e.f);
        end
    endtask

    // Issue one operation on requester n, wait for its response, check it.
    task automatic run_op(input logic n, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] er, input logic [3:0] ef,
                          input string tag);
        int k;
        @(negedge clk);
        if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = op; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = op; end
        #1;
        k = 0;
        while (!(n ? req1_ready : req0_ready) && k < 20) begin @(negedge clk); #1; k++; end
        chk({tag, "_accept"}, (n ? req1_ready : req0_ready), 1'b1);
        push_exp(n, a, b, op);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        k = 0;
        while (!(n ? rsp1_valid : rsp0_valid) && k < 20) begin @(negedge clk); #1; k++; end
        chk({tag, "_latency"}, k, 1);
        pop_chk(tag);
        chk({tag, "_r_const"}, (n ? rsp1_r : rsp0_r), er);
        chk({tag, "_flags_const"}, (n ? rsp1_flags : rsp0_flags), ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g[$];
        int f_g0, f_g1;
        int exp_g[4];

        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'hDEAD; req0_b = 32'hBEEF; req0_aluc = ALUC_ADD;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_aluc = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;

        // reset behaviour with requests already pending
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("post_rst_alu_b", alu_b, 32'd0);
        chk("post_rst_aluc", alu_aluc, 4'd0);
        chk("post_rst_rsp0_r", rsp0_r, 32'd0);
        chk("post_rst_busy", busy, 1'b0);

        // ADD 5+3, cycle-by-cycle latency and busy
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluc = ALUC_ADD;
        #1;
        chk("add_ready_T", req0_ready, 1'b1);
        chk("add_busy_T", busy, 1'b0);
        push_exp(1'b0, 32'd5, 32'd3, ALUC_ADD);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk("add_busy_T1", busy, 1'b1);
        chk("add_rsp_T1", rsp0_valid, 1'b0);
        chk("add_alu_a_T1", alu_a, 32'd5);
        chk("add_alu_b_T1", alu_b, 32'd3);
        @(negedge clk); #1;
        chk("add_busy_T2", busy, 1'b1);
        pop_chk("add");
        chk("add_r", rsp0_r, 32'd8);
        chk("add_flags", rsp0_flags, 4'b0000);
        @(negedge clk); #1;
        chk("add_busy_T3", busy, 1'b0);
        chk("add_rsp_T3", rsp0_valid, 1'b0);

        run_op(1'b0, 32'h7FFF_FFFF, 32'd1, ALUC_ADD, 32'h8000_0000, 4'b0011, "add_ovf");
        run_op(1'b0, 32'd4, 32'd4, ALUC_SUB, 32'd0, 4'b1000, "sub_zero");
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, ALUC_SLT, 32'd1, 4'b0000, "slt");
        run_op(1'b1, 32'd4, 32'd1, ALUC_SLL, 32'd16, 4'b0000, "sll");
        run_op(1'b0, 32'd1, 32'd2, ALUC_SUBU, 32'hFFFF_FFFF, 4'b0110, "subu_borrow");

        // both requesters valid continuously from reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_aluc = ALUC_ADDU;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_aluc = ALUC_SUBU;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1;
        f_g0 = 0; f_g1 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready) begin g.push_back(0); push_exp(1'b0, 32'd10, 32'd1, ALUC_ADDU); end
            if (req1_ready) begin g.push_back(1); push_exp(1'b1, 32'd20, 32'd2, ALUC_SUBU); end
            if (rsp0_valid || rsp1_valid) pop_chk("rr_rsp");
            if (f_req0_ready) f_g0++;
            if (f_req1_ready) f_g1++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        exp_g = '{0, 1, 0, 1};
        chk("rr_grant_count", g.size(), 4);
        for (int i = 0; i < 4 && i < g.size(); i++) chk($sformatf("rr_grant_%0d", i), g[i], exp_g[i]);
        chk("rr_sb_drained", sb.size(), 0);
        chk("fixed_grants0", f_g0, 4);
        chk("fixed_grants1", f_g1, 0);

        // requester 1 result held while rsp1_ready is low
        rsp1_ready = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd58; req1_aluc = ALUC_SUB;
        #1;
        chk("hold_accept", req1_ready, 1'b1);
        push_exp(1'b1, 32'd100, 32'd58, ALUC_SUB);
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        pop_chk("hold_first");
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_aluc = ALUC_SUBU;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("hold_rsp1_valid", rsp1_valid, 1'b1);
            chk("hold_rsp1_r", rsp1_r, 32'd42);
            chk("hold_rsp1_flags", rsp1_flags, 4'b0000);
            chk("hold_req0_ready", req0_ready, 1'b0);
            chk("hold_rsp0_valid", rsp0_valid, 1'b0);
        end
        rsp1_ready = 1'b1;
        @(negedge clk); #1;
        chk("release_rsp1_valid", rsp1_valid, 1'b0);
        chk("release_req0_ready", req0_ready, 1'b1);
        push_exp(1'b0, 32'd7, 32'd7, ALUC_SUBU);
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        pop_chk("release_rsp");
        chk("release_flags_const", rsp0_flags, 4'b1000);

        // reset while in EXEC discards the operation
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_aluc = ALUC_ADDU;
        #1;
        chk("abort_accept", req1_ready, 1'b1);
        @(negedge clk); req1_valid = 1'b0; #1;
        chk("abort_exec_busy", busy, 1'b1);
        rst = 1'b1; #1;
        chk("abort_rst_busy", busy, 1'b0);
        chk("abort_rst_rsp1", rsp1_valid, 1'b0);
        chk("abort_rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd9; req0_aluc = ALUC_ADD;
        req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd1; req1_aluc = ALUC_ADD;
        #1;
        chk("abort_busy_idle", busy, 1'b0);
        chk("abort_grant0", req0_ready, 1'b1);
        chk("abort_grant1", req1_ready, 1'b0);
        push_exp(1'b0, 32'd6, 32'd9, ALUC_ADD);
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort_no_rsp1", rsp1_valid, 1'b0);
            if (rsp0_valid) pop_chk("abort_next");
            @(negedge clk);
        end
        chk("abort_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
